// File: rtl/mmio_uart_ctrl.sv
// MMIO UART controller: TX FIFO, RX holding register, cycle/instret counters; loads return data one cycle later.
// Backpressure: stores to a full TX FIFO are dropped; the receiver is stalled while the RX holding register is occupied.
module mmio_uart_ctrl #(
  parameter int TX_DEPTH = 4,
  parameter int CNT_W    = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic        is_uart,
  input  logic        mem_re,
  input  logic        mem_we,
  input  logic [31:0] wdata,
  input  logic        inst_retired,
  output logic [31:0] rdata,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready
);

  localparam int PTR_W = $clog2(TX_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(TX_DEPTH);

  localparam logic [5:0] OFF_STATUS = 6'h00;
  localparam logic [5:0] OFF_RXDATA = 6'h01;
  localparam logic [5:0] OFF_TXDATA = 6'h02;
  localparam logic [5:0] OFF_CYCLE  = 6'h04;
  localparam logic [5:0] OFF_INST   = 6'h05;
  localparam logic [5:0] OFF_CNTRST = 6'h06;

  logic [7:0]       mem_q [TX_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             hold_vld_q, hold_vld_d;
  logic [7:0]       hold_dat_q, hold_dat_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] inst_q, inst_d;
  logic [31:0]      rdata_q, rdata_d;

  logic [5:0] off;
  logic       rd_en, wr_en, full, push, pop, capture, rx_clr, cnt_clr;
  logic       unused_ok;

  assign unused_ok = ^{addr[31:8], addr[1:0], wdata[31:8]};

  assign off     = addr[7:2];
  assign rd_en   = mem_re & is_uart;
  assign wr_en   = mem_we & is_uart;
  assign full    = (count_q == FULL_CNT);
  // A full FIFO refuses the push even when it pops in the same cycle.
  assign push    = wr_en & (off == OFF_TXDATA) & ~full;
  assign pop     = uart_tx_valid & uart_tx_ready;
  assign capture = uart_rx_valid & uart_rx_ready;
  assign rx_clr  = rd_en & (off == OFF_RXDATA) & hold_vld_q;
  assign cnt_clr = wr_en & (off == OFF_CNTRST);

  assign uart_tx_valid = (count_q != '0);
  assign uart_tx_data  = mem_q[rd_ptr_q];
  assign uart_rx_ready = ~hold_vld_q;
  assign rdata         = rdata_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    hold_vld_d = hold_vld_q;
    hold_dat_d = hold_dat_q;
    cyc_d      = cyc_q + CNT_W'(1);
    inst_d     = inst_q + CNT_W'(inst_retired);
    rdata_d    = rdata_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      count_d = count_q + (PTR_W + 1)'(1);
    else if (pop && !push) count_d = count_q - (PTR_W + 1)'(1);

    if (capture) begin
      hold_vld_d = 1'b1;
      hold_dat_d = uart_rx_data;
    end else if (rx_clr) begin
      hold_vld_d = 1'b0;
    end

    if (cnt_clr) begin
      cyc_d  = '0;
      inst_d = '0;
    end

    // Read mux sees pre-edge state, so same-cycle updates are not visible.
    if (rd_en) begin
      case (off)
        OFF_STATUS: rdata_d = {30'b0, hold_vld_q, ~full};
        OFF_RXDATA: rdata_d = hold_vld_q ? {24'b0, hold_dat_q} : 32'b0;
        OFF_CYCLE:  rdata_d = 32'(cyc_q);
        OFF_INST:   rdata_d = 32'(inst_q);
        default:    rdata_d = 32'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < TX_DEPTH; i++) mem_q[i] <= 8'h00;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      hold_vld_q <= 1'b0;
      hold_dat_q <= 8'h00;
      cyc_q      <= '0;
      inst_q     <= '0;
      rdata_q    <= 32'b0;
    end else begin
      if (push) mem_q[wr_ptr_q] <= wdata[7:0];
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      hold_vld_q <= hold_vld_d;
      hold_dat_q <= hold_dat_d;
      cyc_q      <= cyc_d;
      inst_q     <= inst_d;
      rdata_q    <= rdata_d;
    end
  end

endmodule

// File: doc/mmio_uart_ctrl.md
Name: mmio_uart_ctrl

Overview:
- Memory-mapped I/O controller for the CPU's UART address space, where the access has addr[31:28] == 4'b1000 and is_uart is high.
- Sequences CPU loads and stores into UART handshakes through a TX FIFO and an RX holding register.
- Exposes status, cycle-counter and retired-instruction-counter registers.
- Sits beside data memory in the MEM stage; read data is registered to match the synchronous data-memory read latency.

Parameters:
- TX_DEPTH, 4, TX FIFO entries; must be a power of 2, minimum 2.
- CNT_W, 32, counter width; read data is zero-extended to 32 bits.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  synchronous reset, active-low
- addr  in  32  word-aligned address from address partitioning; only addr[7:2] is decoded
- is_uart  in  1  access targets I/O space; reads and writes are ignored when low
- mem_re  in  1  load strobe
- mem_we  in  1  store strobe
- wdata  in  32  store data; only wdata[7:0] is used
- inst_retired  in  1  one pulse per retired instruction
- rdata  out  32  load data, valid the cycle after the load
- uart_tx_data  out  8  byte to transmitter
- uart_tx_valid  out  1  TX FIFO non-empty
- uart_tx_ready  in  1  transmitter accepts the byte
- uart_rx_data  in  8  byte from receiver
- uart_rx_valid  in  1  receiver has a byte
- uart_rx_ready  out  1  holding register empty

Behaviour:
- Reset (rst_n low at a clock edge) produces:
  - TX FIFO empty: uart_tx_valid=0, uart_tx_data=0.
  - RX hold empty: uart_rx_ready=1.
  - Both counters = 0; rdata = 0.
  - Reset mid-transfer discards FIFO contents and the held byte.
- Register map, by addr[7:0]:
  - 0x00 status (R): bit0 = TX FIFO not full, bit1 = RX hold valid, other bits 0.
  - 0x04 rx_data (R): {24'b0, held byte}; a read clears RX hold valid. Reading while empty returns 0 and has no side effect.
  - 0x08 tx_data (W): pushes wdata[7:0] into the TX FIFO.
  - 0x10 cycle_cnt (R).
  - 0x14 inst_cnt (R).
  - 0x18 cnt_reset (W): any write zeroes both counters.
- Addresses are decoded only on addr[7:2]; addr[27:8] aliases. Reads of unmapped offsets return 0; writes to unmapped or read-only offsets are ignored.
- Read latency: rdata is updated at the edge after a cycle with mem_re & is_uart and holds until the next such read.
  - rdata reflects state before that edge's updates. Example: a read of status in the same cycle as a push shows the pre-push full flag.
- mem_re and mem_we in the same cycle: both take effect.
- TX FIFO:
  - Push when mem_we & is_uart & offset 0x08 & not full.
  - A push while full is silently dropped, even if a pop occurs the same cycle.
  - Pop when uart_tx_valid & uart_tx_ready.
  - Push and pop in the same cycle on a non-empty FIFO: count unchanged.
  - uart_tx_data is the head entry, combinational from FIFO storage. It holds stable while valid and not ready.
  - Pointers wrap modulo TX_DEPTH; full when count == TX_DEPTH.
- RX:
  - Capture uart_rx_data when uart_rx_valid & uart_rx_ready; hold becomes valid next cycle. uart_rx_ready = ~hold_valid.
  - A read of 0x04 while valid clears the hold; uart_rx_ready rises the next cycle.
- Counters:
  - cycle_cnt increments every cycle; inst_cnt increments when inst_retired=1. Both wrap 2^CNT_W-1 -> 0.
  - A cnt_reset write makes both counters 0 at the next edge; this overrides the same-cycle increment.

Test Plan:
- Reset, then read status -> rdata = 0x00000001 next cycle; uart_tx_valid=0; uart_rx_ready=1.
- With uart_tx_ready=0, write 0x41,0x42,0x43,0x44,0x45 to 0x80000008:
  - status read -> 0x00000000 (full);
  - raise tx_ready -> uart_tx_data sequence 0x41,0x42,0x43,0x44; 0x45 is dropped; then uart_tx_valid=0.
- Drive uart_rx_valid=1, data=0x5A for one cycle:
  - uart_rx_ready drops; status read -> 0x00000003;
  - read 0x80000004 -> 0x0000005A; next cycle uart_rx_ready=1;
  - a second read of 0x80000004 -> 0.
- Run 100 cycles with inst_retired high every other cycle, then write 0x80000018 -> next reads of 0x10 and 0x14 return small values counted from 0, not 100/50.
- Preload cycle_cnt near 0xFFFFFFFF (force) -> wraps to 0 and keeps counting; read of unmapped 0x8000003C -> 0; mem_we with is_uart=0 -> no FIFO push.
- Assert rst_n low with 3 bytes queued and an RX byte held -> uart_tx_valid=0 and uart_rx_ready=1 after that edge; FIFO is empty after reset.
